// File: rtl/ext_irq_pkg.sv
// Shared constants for the external interrupt controller: register byte offsets
// and the per-source trigger mode encoding.
package ext_irq_pkg;

  localparam logic [7:0] REG_ENABLE    = 8'h00;
  localparam logic [7:0] REG_MODE      = 8'h04;
  localparam logic [7:0] REG_POLARITY  = 8'h08;
  localparam logic [7:0] REG_PENDING   = 8'h0C;
  localparam logic [7:0] REG_THRESHOLD = 8'h10;
  localparam logic [7:0] REG_CLAIM     = 8'h14;
  localparam logic [7:0] PRIO_BASE     = 8'h40;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational max-priority finder over the candidate sources.
// Ties resolve to the lowest index; the result is an ID (index+1), 0 when nobody qualifies.
module irq_prio_arb #(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0]             cand,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]                win_id
);

  logic [PRIO_W-1:0] best_prio;

  // Strict greater-than keeps the earliest (lowest ID) source on equal priority.
  always_comb begin
    best_prio = '0;
    win_id    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        win_id    = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller feeding the core's MEIP: synchronised, polarised
// sources with per-source enable/mode/priority, a global threshold and claim/complete.
module ext_irq_ctrl
  import ext_irq_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 5
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_sel,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id
);

  localparam logic [5:0] NUM_SRC_W = 6'(NUM_SRC);

  logic [NUM_SRC-1:0]             sync1, sync2, pol_prev, pol, edge_set;
  logic [NUM_SRC-1:0]             enable, mode, polarity, pending, in_service;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]              threshold;
  logic [NUM_SRC-1:0]             cand, claim_hit, complete_hit, w1c;
  logic [ID_W-1:0]                win_id;
  logic                           rd, wr, claim, complete;
  logic [7:0]                     prio_off;
  logic [5:0]                     prio_idx;
  logic                           prio_hit;
  logic [31:0]                    rd_val;
  logic                           unused_wdata;

  assign rd       = cfg_sel & ~cfg_we;
  assign wr       = cfg_sel & cfg_we;
  assign claim    = rd && (cfg_addr == REG_CLAIM);
  assign complete = wr && (cfg_addr == REG_CLAIM);

  assign prio_off = cfg_addr - PRIO_BASE;
  assign prio_idx = prio_off[7:2];
  assign prio_hit = (cfg_addr >= PRIO_BASE) && (cfg_addr[1:0] == 2'b00) &&
                    (prio_idx < NUM_SRC_W);

  assign pol      = sync2 ^ polarity;
  assign edge_set = pol & ~pol_prev;
  assign w1c      = (wr && (cfg_addr == REG_PENDING)) ? (cfg_wdata[NUM_SRC-1:0] & mode) : '0;

  assign unused_wdata = ^cfg_wdata;

  // Completing an ID that is 0, out of range or idle matches no bit, so it is a no-op.
  always_comb begin
    cand         = '0;
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand[i]         = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
      claim_hit[i]    = claim && (win_id == ID_W'(i + 1));
      complete_hit[i] = complete && (cfg_wdata[ID_W-1:0] == ID_W'(i + 1));
    end
  end

  irq_prio_arb #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_arb (
    .cand   (cand),
    .prio   (prio),
    .win_id (win_id)
  );

  always_comb begin
    rd_val = '0;
    case (cfg_addr)
      REG_ENABLE:    rd_val = 32'(enable);
      REG_MODE:      rd_val = 32'(mode);
      REG_POLARITY:  rd_val = 32'(polarity);
      REG_PENDING:   rd_val = 32'(pending);
      REG_THRESHOLD: rd_val = 32'(threshold);
      REG_CLAIM:     rd_val = 32'(win_id);
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (prio_hit && (prio_idx == 6'(i))) rd_val = 32'(prio[i]);
        end
      end
    endcase
  end

  // A new edge overrides a claim or W1C landing on the same cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sync1      <= '0;
      sync2      <= '0;
      pol_prev   <= '0;
      enable     <= '0;
      mode       <= '0;
      polarity   <= '0;
      pending    <= '0;
      in_service <= '0;
      prio       <= '0;
      threshold  <= '0;
      cfg_rdata  <= '0;
      irq_req    <= 1'b0;
      irq_id     <= '0;
    end else begin
      sync1      <= irq_src;
      sync2      <= sync1;
      pol_prev   <= pol;
      irq_req    <= (win_id != '0);
      irq_id     <= win_id;
      in_service <= (in_service | claim_hit) & ~complete_hit;
      if (rd) cfg_rdata <= rd_val;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (mode[i] == MODE_LEVEL) pending[i] <= pol[i];
        else pending[i] <= edge_set[i] | (pending[i] & ~(claim_hit[i] | w1c[i]));
      end
      if (wr) begin
        case (cfg_addr)
          REG_ENABLE:    enable    <= cfg_wdata[NUM_SRC-1:0];
          REG_MODE:      mode      <= cfg_wdata[NUM_SRC-1:0];
          REG_POLARITY:  polarity  <= cfg_wdata[NUM_SRC-1:0];
          REG_THRESHOLD: threshold <= cfg_wdata[PRIO_W-1:0];
          default: begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (prio_hit && (prio_idx == 6'(i))) prio[i] <= cfg_wdata[PRIO_W-1:0];
            end
          end
        endcase
      end
    end
  end

endmodule
